// File: rtl/sd_write.sv
// rtl/sd_write.sv - SPI-mode SD single-block write (CMD24) engine
// Optional feature macro: SD_WRITE_TIMEOUT_EN bounds the R1, data-response and busy waits.
module sd_write (
    input  logic        SD_clk,
    input  logic        init,
    output logic        SD_cs,
    output logic        SD_datain,
    input  logic        SD_dataout,
    input  logic        start,
    input  logic [31:0] sec_addr,
    output logic        data_req,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SEND_CMD   = 4'd1,
        WAIT_R1    = 4'd2,
        GAP        = 4'd3,
        SEND_TOKEN = 4'd4,
        SEND_DATA  = 4'd5,
        SEND_CRC   = 4'd6,
        WAIT_RESP  = 4'd7,
        WAIT_BUSY  = 4'd8,
        FINISH     = 4'd9
    } state_t;

    state_t      state_q;
    logic        cs_q, din_q, dreq_q, busy_q, done_q, err_q, rx_act_q;
    logic [47:0] sh_q;
    logic [5:0]  cnt_q;
    logic [7:0]  wcnt_q;
    logic [7:0]  rx_q;
    logic [7:0]  rx_d;
    logic [47:0] cmd_d;
`ifdef SD_WRITE_TIMEOUT_EN
    logic [21:0] tmo_q;
`endif

    assign rx_d  = {rx_q[6:0], SD_dataout};
    assign cmd_d = {8'h58, sec_addr, 8'hFF};

    assign SD_cs     = cs_q;
    assign SD_datain = din_q;
    assign data_req  = dreq_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_o   = state_q;

    // Write sequencer: every output is registered and reflects the current state.
    always_ff @(posedge SD_clk or negedge init) begin
        if (!init) begin
            state_q  <= IDLE;
            cs_q     <= 1'b1;
            din_q    <= 1'b1;
            dreq_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rx_act_q <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            rx_q     <= '0;
`ifdef SD_WRITE_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            dreq_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cs_q  <= 1'b1;
                    din_q <= 1'b1;
                    if (start) begin
                        cs_q    <= 1'b0;
                        din_q   <= cmd_d[47];
                        sh_q    <= {cmd_d[46:0], 1'b0};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (cnt_q == 6'd47) begin
                        din_q    <= 1'b1;
                        cnt_q    <= '0;
                        rx_act_q <= 1'b0;
                        rx_q     <= '0;
`ifdef SD_WRITE_TIMEOUT_EN
                        tmo_q    <= '0;
`endif
                        state_q  <= WAIT_R1;
                    end else begin
                        din_q <= sh_q[47];
                        sh_q  <= {sh_q[46:0], 1'b0};
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                WAIT_R1: begin
                    if (rx_act_q) begin
                        rx_q  <= rx_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd7) begin
                            rx_act_q <= 1'b0;
                            cnt_q    <= '0;
                            if (rx_d == 8'h00) begin
                                state_q <= GAP;
                            end else begin
                                err_q   <= 1'b1;
                                cs_q    <= 1'b1;
                                state_q <= FINISH;
                            end
                        end
                    end else if (!SD_dataout) begin
                        // The first zero is the R1 MSB, so it is already bit 1 of 8.
                        rx_act_q <= 1'b1;
                        rx_q     <= rx_d;
                        cnt_q    <= 6'd1;
                    end
`ifdef SD_WRITE_TIMEOUT_EN
                    else if (tmo_q == 22'd63) begin
                        err_q   <= 1'b1;
                        cs_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= FINISH;
                    end else begin
                        tmo_q <= tmo_q + 22'd1;
                    end
`endif
                end
                GAP: begin
                    din_q <= 1'b1;
                    if (cnt_q == 6'd7) begin
                        // Token 8'hFE: MSB driven now, remaining bits left in the shifter.
                        sh_q    <= {8'hFC, 40'h0};
                        cnt_q   <= '0;
                        state_q <= SEND_TOKEN;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                SEND_TOKEN: begin
                    if (cnt_q == 6'd5) dreq_q <= 1'b1;
                    if (cnt_q == 6'd7) begin
                        din_q   <= wr_data[15];
                        sh_q    <= {wr_data[14:0], 33'h0};
                        cnt_q   <= '0;
                        wcnt_q  <= '0;
                        state_q <= SEND_DATA;
                    end else begin
                        din_q <= sh_q[47];
                        sh_q  <= {sh_q[46:0], 1'b0};
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                SEND_DATA: begin
                    // Request the next word while bit 1 of the current one is on the wire.
                    if (cnt_q == 6'd13 && wcnt_q != 8'd255) dreq_q <= 1'b1;
                    if (cnt_q == 6'd15) begin
                        cnt_q <= '0;
                        if (wcnt_q == 8'd255) begin
                            din_q   <= 1'b1;
                            state_q <= SEND_CRC;
                        end else begin
                            wcnt_q <= wcnt_q + 8'd1;
                            din_q  <= wr_data[15];
                            sh_q   <= {wr_data[14:0], 33'h0};
                        end
                    end else begin
                        din_q <= sh_q[47];
                        sh_q  <= {sh_q[46:0], 1'b0};
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                SEND_CRC: begin
                    din_q <= 1'b1;
                    if (cnt_q == 6'd15) begin
                        cnt_q    <= '0;
                        rx_act_q <= 1'b0;
                        rx_q     <= '0;
`ifdef SD_WRITE_TIMEOUT_EN
                        tmo_q    <= '0;
`endif
                        state_q  <= WAIT_RESP;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                WAIT_RESP: begin
                    if (rx_act_q) begin
                        rx_q  <= rx_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd4) begin
                            // Token is 0,s2,s1,s0,1; only status 010 means accepted.
                            rx_act_q <= 1'b0;
                            cnt_q    <= '0;
                            if (rx_d[3:1] == 3'b010) begin
`ifdef SD_WRITE_TIMEOUT_EN
                                tmo_q   <= '0;
`endif
                                state_q <= WAIT_BUSY;
                            end else begin
                                err_q   <= 1'b1;
                                cs_q    <= 1'b1;
                                state_q <= FINISH;
                            end
                        end
                    end else if (!SD_dataout) begin
                        rx_act_q <= 1'b1;
                        rx_q     <= rx_d;
                        cnt_q    <= 6'd1;
                    end
`ifdef SD_WRITE_TIMEOUT_EN
                    else if (tmo_q == 22'd63) begin
                        err_q   <= 1'b1;
                        cs_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= FINISH;
                    end else begin
                        tmo_q <= tmo_q + 22'd1;
                    end
`endif
                end
                WAIT_BUSY: begin
                    if (SD_dataout) begin
                        done_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= FINISH;
                    end
`ifdef SD_WRITE_TIMEOUT_EN
                    else if (tmo_q == 22'h3FFFFF) begin
                        err_q   <= 1'b1;
                        cs_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= FINISH;
                    end else begin
                        tmo_q <= tmo_q + 22'd1;
                    end
`endif
                end
                FINISH: begin
                    cs_q  <= 1'b1;
                    din_q <= 1'b1;
                    if (cnt_q == 6'd7) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: begin
                    cs_q    <= 1'b1;
                    din_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_write.md
SD_WRITE -- requirements
Module: sd_write

Interface
REQ-001 SD_clk  input  1  SPI bit clock; all logic on rising edge.
REQ-002 init  input  1  asynchronous active-low reset; low forces reset state immediately.
REQ-003 SD_cs  output  1  card chip select, active low.
REQ-004 SD_datain  output  1  MOSI to card, registered, MSB first.
REQ-005 SD_dataout  input  1  MISO from card, sampled on rising edge.
REQ-006 start  input  1  one-cycle write request; honoured only in IDLE.
REQ-007 sec_addr  input  32  target sector, latched on accepted start.
REQ-008 data_req  output  1  one-cycle pulse requesting the next 16-bit word.
REQ-009 wr_data  input  16  word to write; sampled one cycle after data_req.
REQ-010 busy  output  1  high from accepted start until done/err pulse.
REQ-011 done  output  1  one-cycle pulse: block accepted and card not busy.
REQ-012 err  output  1  one-cycle pulse: R1 non-zero, response rejected or timeout.
REQ-013 state_o  output  4  current state code, for debug.

Function
REQ-014 States: IDLE=0, SEND_CMD=1, WAIT_R1=2, GAP=3, SEND_TOKEN=4, SEND_DATA=5, SEND_CRC=6, WAIT_RESP=7, WAIT_BUSY=8, FINISH=9; undefined codes return to IDLE.
REQ-015 IDLE: SD_cs=1, SD_datain=1; start -> latch sec_addr, load CMD24 {8'h58, sec_addr[31:24..7:0], 8'hFF}, busy=1, go SEND_CMD.
REQ-016 SEND_CMD: SD_cs=0, shift 48 command bits MSB first, one per cycle, then SD_datain=1, go WAIT_R1.
REQ-017 WAIT_R1: first sampled 0 on SD_dataout is R1 bit7; capture 8 bits; R1==8'h00 -> GAP, else err pulse -> FINISH.
REQ-018 GAP: drive 8 cycles of 1, then SEND_TOKEN.
REQ-019 SEND_TOKEN: drive 8'hFE MSB first.
REQ-020 SEND_DATA: 256 words, 16 bits each MSB first, 4096 cycles total, no idle bits between words.
REQ-021 data_req asserted during the cycle driving bit1 of the token or of words 0..254; wr_data captured on the edge ending the bit0 cycle; exactly 256 pulses per block.
REQ-022 SEND_CRC: drive 16 bits of 1 (dummy CRC), then WAIT_RESP.
REQ-023 WAIT_RESP: first sampled 0 starts the token; capture 5 bits 0,s2,s1,s0,1; s==3'b010 -> WAIT_BUSY, else err -> FINISH.
REQ-024 WAIT_BUSY: remain while SD_dataout==0; first sampled 1 -> done pulse, FINISH.
REQ-025 FINISH: SD_cs=1, SD_datain=1 for 8 cycles, busy=0 on exit, then IDLE; done/err pulse coincides with entry to FINISH.
REQ-026 start while busy is ignored; start in same cycle as FINISH exit is ignored.
REQ-027 done and err never assert in the same cycle.

Reset
REQ-028 init low: state IDLE, SD_cs=1, SD_datain=1, data_req=0, busy=0, done=0, err=0, all counters/shift registers 0, asynchronously.
REQ-029 init low mid-transfer aborts immediately, no done/err pulse; after release the block waits for a new start.

Configuration
REQ-030 SD_WRITE_TIMEOUT_EN defined: WAIT_R1 limited to 64 cycles, WAIT_RESP to 64 cycles, WAIT_BUSY to 2^22 cycles; expiry -> err pulse, FINISH.
REQ-031 SD_WRITE_TIMEOUT_EN undefined: no timeout counter; wait states hold indefinitely.

Verification
REQ-032 start, sec_addr=32'd16448, card model R1=00, token 8'hE5, busy 100 cycles -> MOSI 58_00_00_40_40_FF, FE, 256 words, FFFF; exactly 256 data_req; one done; err=0.
REQ-033 Card returns R1=8'h04 -> err pulse, no FE token, SD_cs high 8 cycles, busy low.
REQ-034 Response token 8'hEB (status 101) -> err pulse, no done.
REQ-035 wr_data = incrementing 16'h0000..16'h00FF -> MOSI data bits match MSB-first sequence, no gaps.
REQ-036 init pulsed low during word 100 -> SD_cs=1, busy=0 same cycle; next start completes normally.
REQ-037 SD_WRITE_TIMEOUT_EN defined, SD_dataout held 1 after command -> err pulse 64 cycles after WAIT_R1 entry.
